// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads a 3-byte instruction (op_code, arg1, arg2)
// from a byte-wide synchronous memory starting at the strobed pc.
module instr_fetch #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              pc_strobe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic [7:0]        op_code,
   output logic [7:0]        arg1,
   output logic [7:0]        arg2,
   output logic              instr_valid,
   output logic              busy
);

   typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, LAST, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        op_q, op_d;
   logic [7:0]        a1_q, a1_d;
   logic [7:0]        a2_q, a2_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         addr_q  <= '0;
         op_q    <= '0;
         a1_q    <= '0;
         a2_q    <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
      end
   end

   // mem_addr is loaded on the edge entering each read state, so it is a
   // flop and naturally holds its last value once reads stop.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      addr_d  = addr_q;
      op_d    = op_q;
      a1_d    = a1_q;
      a2_d    = a2_q;
      if (pc_strobe) begin
         // A strobe in any state (re)starts the fetch; partial bytes are dropped.
         state_d = RD0;
         base_d  = pc;
         addr_d  = pc;
      end else begin
         case (state_q)
            RD0: begin
               state_d = RD1;
               addr_d  = base_q + ADDR_W'(1);
            end
            RD1: begin
               state_d = RD2;
               addr_d  = base_q + ADDR_W'(2);
               op_d    = mem_data;
            end
            RD2: begin
               state_d = LAST;
               a1_d    = mem_data;
            end
            LAST: begin
               state_d = DONE;
               a2_d    = mem_data;
            end
            IDLE, DONE: state_d = state_q;
            default:    state_d = IDLE;
         endcase
      end
   end

   assign mem_addr    = addr_q;
   assign mem_rd      = (state_q == RD0) || (state_q == RD1) || (state_q == RD2);
   assign busy        = mem_rd || (state_q == LAST);
   assign instr_valid = (state_q == DONE);
   assign op_code     = op_q;
   assign arg1        = a1_q;
   assign arg2        = a2_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected addresses and
// instruction triples, a negedge monitor pops and compares them.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pc = '0;
   logic        pc_strobe = 1'b0;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data = '0;
   logic [7:0]  op_code, arg1, arg2;
   logic        instr_valid, busy;

   int total = 0;
   int bad   = 0;

   logic [7:0]  mem [0:65535];
   logic [15:0] addr_q [$];
   logic [23:0] trip_q [$];
   logic        prev_valid = 1'b0;

   instr_fetch #(.ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_strobe(pc_strobe),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
      .op_code(op_code), .arg1(arg1), .arg2(arg2),
      .instr_valid(instr_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   // synchronous-read memory: data appears one edge after the address edge
   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
      end
   endtask

   // monitor: every read address and every completed instruction is checked
   always @(negedge clk) begin
      if (mem_rd) begin
         if (addr_q.size() == 0) chk("unexpected_read", {16'h0, mem_addr}, 32'hFFFF_FFFF);
         else chk("mem_addr", {16'h0, mem_addr}, {16'h0, addr_q.pop_front()});
      end
      if (instr_valid && !prev_valid) begin
         if (trip_q.size() == 0) chk("unexpected_valid", {8'h0, op_code, arg1, arg2}, 32'hFFFF_FFFF);
         else chk("triple", {8'h0, op_code, arg1, arg2}, {8'h0, trip_q.pop_front()});
      end
      prev_valid = instr_valid;
   end

   task automatic strobe(input logic [15:0] a);
      @(negedge clk);
      pc = a;
      pc_strobe = 1'b1;
      @(negedge clk);
      pc_strobe = 1'b0;
   endtask

   task automatic expect_fetch(input logic [15:0] a, input logic [23:0] t);
      addr_q.push_back(a);
      addr_q.push_back(a + 16'd1);
      addr_q.push_back(a + 16'd2);
      trip_q.push_back(t);
   endtask

   // counts negedges with instr_valid low, starting at the current one
   task automatic wait_valid(input string name, input int exp_lows);
      int lows = 0;
      while (!instr_valid && lows < 20) begin
         lows++;
         @(negedge clk);
      end
      chk(name, lows, exp_lows);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h3B;
      mem[16'h10] = 8'h91; mem[16'h11] = 8'h92; mem[16'h12] = 8'h93;
      mem[16'h20] = 8'hC1; mem[16'h21] = 8'hC2; mem[16'h22] = 8'hC3;
      mem[3] = 8'h33; mem[4] = 8'h44; mem[5] = 8'h55;
      mem[16'hFFFF] = 8'hA7;

      // reset state
      #3;
      chk("rst_outputs", {mem_addr, mem_rd, instr_valid, busy, 5'b0, op_code | arg1 | arg2}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // basic fetch with cycle-exact timing
      expect_fetch(16'h0000, 24'h10053B);
      strobe(16'h0000);
      chk("basic_c1", {mem_rd, busy, instr_valid, mem_addr}, {3'b110, 16'h0000});
      @(negedge clk);
      chk("basic_c2", {mem_rd, busy, instr_valid, mem_addr}, {3'b110, 16'h0001});
      @(negedge clk);
      chk("basic_c3", {mem_rd, busy, instr_valid, mem_addr}, {3'b110, 16'h0002});
      @(negedge clk);
      chk("basic_c4", {mem_rd, busy, instr_valid}, 3'b010);
      @(negedge clk);
      chk("basic_done", {mem_rd, busy, instr_valid, op_code, arg1, arg2}, {3'b001, 24'h10053B});

      // restart in RD2: the 0x10 fetch must never complete
      addr_q.push_back(16'h10); addr_q.push_back(16'h11); addr_q.push_back(16'h12);
      expect_fetch(16'h0020, 24'hC1C2C3);
      strobe(16'h0010);
      @(negedge clk);
      strobe(16'h0020);
      wait_valid("restart_latency", 4);
      chk("restart_bytes", {op_code, arg1, arg2}, 24'hC1C2C3);

      // reset in RD1, plus a strobe that must be ignored during reset
      addr_q.push_back(16'h40); addr_q.push_back(16'h41);
      strobe(16'h0040);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_mid", {mem_rd, busy, instr_valid, op_code}, 11'h000);
      pc = 16'h0050;
      pc_strobe = 1'b1;
      @(negedge clk);
      pc_strobe = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("post_rst_idle", {instr_valid, busy, mem_rd}, 3'b000);
      end

      // address wrap
      mem[0] = 8'h01; mem[1] = 8'h02;
      expect_fetch(16'hFFFF, 24'hA70102);
      strobe(16'hFFFF);
      wait_valid("wrap_latency", 4);
      chk("wrap_bytes", {op_code, arg1, arg2}, 24'hA70102);

      // back-to-back: new strobe in the DONE cycle
      expect_fetch(16'h0000, 24'h01023B);
      expect_fetch(16'h0003, 24'h334455);
      strobe(16'h0000);
      wait_valid("b2b_first", 4);
      strobe(16'h0003);
      wait_valid("b2b_gap", 4);

      // hold in DONE
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold", {instr_valid, mem_rd, busy, op_code, arg1, arg2}, {3'b100, 24'h334455});
      end

      chk("addr_q_empty", addr_q.size(), 0);
      chk("trip_q_empty", trip_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
